// File: rtl/fetch_queue.sv
//==============================================================================
// Module      : fetch_queue
// Description : Fetch-to-decode decoupling FIFO of {pc, inst} pairs with
//               synchronous flush, occupancy output and a saturating
//               decode-stall cycle counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_queue #(
    parameter int DBITS = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fe_valid,
    input  logic [DBITS-1:0]   fe_pc,
    input  logic [DBITS-1:0]   fe_inst,
    output logic               fe_ready,
    output logic               de_valid,
    output logic [DBITS-1:0]   de_pc,
    output logic [DBITS-1:0]   de_inst,
    input  logic               de_ready,
    input  logic               flush,
    output logic [PTR_W:0]     count,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam logic [PTR_W:0]   c_full      = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] c_stall_max = '1;

    logic [DBITS-1:0] r_pc_mem   [DEPTH];
    logic [DBITS-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_stall;

    logic w_enq;
    logic w_deq;
    logic w_stall;

    // Full/empty come from registered count only, so fe_ready never sees de_ready.
    assign fe_ready     = (r_count != c_full);
    assign de_valid     = (r_count != '0);
    assign de_pc        = r_pc_mem[r_rd_ptr];
    assign de_inst      = r_inst_mem[r_rd_ptr];
    assign count        = r_count;
    assign stall_cycles = r_stall;

    assign w_enq   = fe_valid & fe_ready & ~flush;
    assign w_deq   = de_valid & de_ready & ~flush;
    assign w_stall = de_valid & ~de_ready & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_inst_mem[i] <= '0;
            end
        end else if (w_enq) begin
            r_pc_mem[r_wr_ptr]   <= fe_pc;
            r_inst_mem[r_wr_ptr] <= fe_inst;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Only reset clears the stall counter; flush leaves it intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (w_stall && (r_stall != c_stall_max)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//==============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue (CNT_W = 4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_queue;

    localparam int c_dbits = 32;
    localparam int c_depth = 4;
    localparam int c_ptr_w = 2;
    localparam int c_cnt_w = 4;

    logic               clk;
    logic               reset;
    logic               fe_valid;
    logic [c_dbits-1:0] fe_pc;
    logic [c_dbits-1:0] fe_inst;
    logic               fe_ready;
    logic               de_valid;
    logic [c_dbits-1:0] de_pc;
    logic [c_dbits-1:0] de_inst;
    logic               de_ready;
    logic               flush;
    logic [c_ptr_w:0]   count;
    logic [c_cnt_w-1:0] stall_cycles;

    int n_cmp;
    int n_err;

    fetch_queue #(
        .DBITS (c_dbits),
        .DEPTH (c_depth),
        .PTR_W (c_ptr_w),
        .CNT_W (c_cnt_w)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fe_valid     (fe_valid),
        .fe_pc        (fe_pc),
        .fe_inst      (fe_inst),
        .fe_ready     (fe_ready),
        .de_valid     (de_valid),
        .de_pc        (de_pc),
        .de_inst      (de_inst),
        .de_ready     (de_ready),
        .flush        (flush),
        .count        (count),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic present(input logic v, input logic [31:0] pc);
        fe_valid = v;
        fe_pc    = pc;
        fe_inst  = inst_of(pc);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        flush    = 1'b0;
        de_ready = 1'b0;
        present(1'b0, 32'h0);
        #1;
        chk("rst_count",    32'(count), 32'd0);
        chk("rst_de_valid", 32'(de_valid), 32'd0);
        chk("rst_fe_ready", 32'(fe_ready), 32'd1);
        chk("rst_de_pc",    de_pc, 32'h0);
        chk("rst_de_inst",  de_inst, 32'h0);
        chk("rst_stall",    32'(stall_cycles), 32'd0);
        tick();
        tick();
        #2 reset = 1'b1;

        // Fill to full with decode stalled
        tick();
        present(1'b1, 32'h100); tick();
        chk("fill1_count", 32'(count), 32'd1);
        chk("fill1_de_pc", de_pc, 32'h100);
        chk("fill1_stall", 32'(stall_cycles), 32'd0);
        present(1'b1, 32'h104); tick();
        present(1'b1, 32'h108); tick();
        present(1'b1, 32'h10C); tick();
        chk("full_count",    32'(count), 32'd4);
        chk("full_fe_ready", 32'(fe_ready), 32'd0);
        chk("full_stall",    32'(stall_cycles), 32'd3);
        present(1'b1, 32'h110); tick(); tick();
        chk("hold_count",   32'(count), 32'd4);
        chk("hold_de_pc",   de_pc, 32'h100);
        chk("hold_de_inst", de_inst, inst_of(32'h100));
        chk("hold_stall",   32'(stall_cycles), 32'd5);

        // Full with simultaneous dequeue: 0x110 must not be written
        de_ready = 1'b1; tick();
        chk("fdq_count",    32'(count), 32'd3);
        chk("fdq_de_pc",    de_pc, 32'h104);
        chk("fdq_fe_ready", 32'(fe_ready), 32'd1);
        chk("fdq_stall",    32'(stall_cycles), 32'd5);
        de_ready = 1'b0; tick();
        chk("retry_count", 32'(count), 32'd4);
        chk("retry_stall", 32'(stall_cycles), 32'd6);
        present(1'b0, 32'h0);
        de_ready = 1'b1;
        chk("drain_pc0", de_pc, 32'h104); tick();
        chk("drain_pc1", de_pc, 32'h108); tick();
        chk("drain_pc2", de_pc, 32'h10C); tick();
        chk("drain_pc3", de_pc, 32'h110);
        chk("drain_inst3", de_inst, inst_of(32'h110)); tick();
        chk("drain_empty_count", 32'(count), 32'd0);
        chk("drain_empty_valid", 32'(de_valid), 32'd0);
        tick();
        chk("empty_ignore_ready", 32'(count), 32'd0);

        // Streaming across pointer wrap-around
        for (int i = 0; i < 10; i++) begin
            present(1'b1, 32'h200 + 32'(4 * i));
            tick();
            chk($sformatf("stream_pc%0d", i), de_pc, 32'h200 + 32'(4 * i));
            chk($sformatf("stream_cnt%0d", i), 32'(count), 32'd1);
        end
        present(1'b0, 32'h0); tick();
        chk("stream_end_count", 32'(count), 32'd0);
        chk("stream_stall",     32'(stall_cycles), 32'd6);

        // Flush with concurrent enqueue
        de_ready = 1'b0;
        present(1'b1, 32'h280); tick();
        present(1'b1, 32'h284); tick();
        chk("pre_flush_count", 32'(count), 32'd2);
        flush = 1'b1;
        present(1'b1, 32'h300); tick();
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(de_valid), 32'd0);
        chk("flush_stall", 32'(stall_cycles), 32'd7);
        present(1'b1, 32'h400); tick();
        present(1'b0, 32'h0);
        chk("post_flush_count", 32'(count), 32'd1);
        chk("post_flush_pc",    de_pc, 32'h400);
        de_ready = 1'b1; tick();
        chk("post_flush_drain", 32'(count), 32'd0);

        // Reset mid-operation, pulsed between edges
        de_ready = 1'b0;
        present(1'b1, 32'h500); tick();
        present(1'b1, 32'h504); tick();
        present(1'b1, 32'h508); tick();
        present(1'b0, 32'h0);
        chk("mid_count", 32'(count), 32'd3);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_count",    32'(count), 32'd0);
        chk("mid_rst_valid",    32'(de_valid), 32'd0);
        chk("mid_rst_de_pc",    de_pc, 32'h0);
        chk("mid_rst_fe_ready", 32'(fe_ready), 32'd1);
        chk("mid_rst_stall",    32'(stall_cycles), 32'd0);
        #1 reset = 1'b1;
        tick();
        chk("mid_after_count", 32'(count), 32'd0);

        // Stall counter saturation at 2^CNT_W-1
        present(1'b1, 32'h600); tick();
        present(1'b0, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", 32'(stall_cycles), 32'd15);
        chk("sat_pc",    de_pc, 32'h600);
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("sat_flush_count", 32'(count), 32'd0);
        tick();
        chk("sat_after_flush", 32'(stall_cycles), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the fetch stage and the decode stage.
- Buffers up to DEPTH fetched {pc, inst} pairs, so a decode stall does not stop fetch until the queue is full.
- Supports a synchronous flush, driven by branch-redirect logic in AGEX, that discards all buffered instructions.
- Exposes occupancy and a saturating decode-stall cycle counter for debug and performance visibility.

Parameters:
- DBITS, 32, width of PC and instruction words.
- DEPTH, 4, number of entries; must be a power of two, ≥ 2.
- PTR_W, 2, log2(DEPTH).
- CNT_W, 32, width of the stall cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- fe_valid  in  1  FE presents a valid instruction.
- fe_pc  in  DBITS  PC of the presented instruction.
- fe_inst  in  DBITS  presented instruction word.
- fe_ready  out  1  queue can accept an entry this cycle.
- de_valid  out  1  head entry is valid.
- de_pc  out  DBITS  head PC.
- de_inst  out  DBITS  head instruction.
- de_ready  in  1  DE consumes the head this cycle.
- flush  in  1  discard all entries (redirect).
- count  out  PTR_W+1  current occupancy, 0..DEPTH.
- stall_cycles  out  CNT_W  saturating count of cycles with de_valid=1 and de_ready=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears the write pointer, read pointer, count and stall_cycles to 0.
  - Clears all storage entries to 0.
  - Outputs while held in reset: de_valid=0, de_pc=0, de_inst=0, fe_ready=1, count=0.
  - On deassertion, the first active edge behaves as normal operation.
- Registered state:
  - Storage array of DEPTH × {pc, inst}.
  - wr_ptr and rd_ptr, each PTR_W bits, wrapping modulo DEPTH.
  - count register, PTR_W+1 bits.
- Outputs:
  - fe_ready = (count != DEPTH). It depends only on registered state, never combinationally on de_ready.
  - de_valid = (count != 0).
  - de_pc and de_inst come combinationally from storage[rd_ptr]. When count=0 they hold stale data and are don't-care.
- Enqueue:
  - Occurs when fe_valid & fe_ready & !flush.
  - Writes storage[wr_ptr]; wr_ptr increments with wrap.
- Dequeue:
  - Occurs when de_valid & de_ready & !flush.
  - rd_ptr increments with wrap.
- Count update:
  - Enqueue only: +1.
  - Dequeue only: −1.
  - Both in the same cycle: unchanged. This is legal at any occupancy 1..DEPTH−1.
  - Neither: unchanged.
- Full: no enqueue is possible, even when a dequeue occurs the same cycle. FE retries next cycle with fe_ready=1.
- Empty: no dequeue is possible. de_ready is ignored.
- Latency:
  - An entry enqueued at edge N is visible on de_valid/de_pc/de_inst after edge N, i.e. one cycle of minimum latency.
  - There is no bypass from fe to de.
- Flush (synchronous, highest priority):
  - At the edge, count, wr_ptr and rd_ptr go to 0.
  - Any same-cycle enqueue or dequeue is discarded.
  - Storage contents are unchanged but are unreachable.
  - de_valid=0 from the next cycle. An FE instruction presented the cycle after flush is accepted normally.
- Stall counter:
  - stall_cycles increments at each edge where de_valid=1, de_ready=0 and flush=0.
  - It saturates at 2^CNT_W−1.
  - It is cleared only by reset, never by flush.
- Ordering: FIFO order is strict. No reordering and no duplication across pointer wrap-around.
- Forbidden: no X propagation from storage to outputs after reset.

Test Plan:
- Reset mid-operation:
  - Stimulus: fill 3 entries, then pulse reset=0 for half a cycle between edges.
  - Required: count=0, de_valid=0, de_pc=0 and fe_ready=1 immediately, before any clock edge.
- Fill to full:
  - Stimulus: de_ready=0; enqueue pc 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles, then hold fe_valid=1 with pc 0x110.
  - Required: count=4, fe_ready=0, de_pc=0x100, 0x110 not accepted; stall_cycles increments by 1 per cycle while held.
- Full with simultaneous dequeue:
  - Stimulus: at count=4, de_ready=1 and fe_valid=1 with pc 0x110.
  - Required: 0x100 consumed, 0x110 not written, count=3; next cycle fe_ready=1 and 0x110 is accepted.
- Streaming across wrap-around:
  - Stimulus: fe_valid=1 and de_ready=1 continuously for 10 instructions, pc 0x200..0x224.
  - Required: after the first one-cycle latency, de_pc follows 0x200, 0x204, …, 0x224 in order, one per cycle, with count steady at 1.
- Flush with concurrent enqueue:
  - Stimulus: count=2 and flush=1 together with fe_valid=1, pc 0x300.
  - Required: next cycle count=0 and de_valid=0; 0x300 dropped; pc 0x400 presented the following cycle appears at de_pc one cycle later.
- Stall counter saturation:
  - Stimulus: CNT_W=4; hold de_valid=1 and de_ready=0 for 20 cycles.
  - Required: stall_cycles=15 and holds; a following flush leaves it at 15.
